jt12_kon_sched: RTL
===================

Name: jt12_kon_sched

Overview:
- Schedules CPU key-on register writes (reg 0x28) into the key-on shift-register datapath.
- Queues decoded writes in a small FIFO and presents the head entry as keyon_op/keyon_ch with up_keyon held high.
- Pops the entry on the exact slot where the datapath samples it: clk_en, channel match, operator 3.
- Sits between the register interface and the key-on unit; it guarantees back-to-back writes to different channels are never lost.

Parameters:
- num_ch, 6, channel count. 6: valid ch codes 0,1,2,4,5,6. 3: valid ch codes 0,1,2.
- depth, 4, FIFO entries. Power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  slot-rate enable; slot counters advance only when high
- wr  in  1  key-on register write strobe; sampled on every clk edge, independent of clk_en
- din  in  8  write data: [7:4] operator mask (S4,S3,S2,S1), [2:0] channel code, [3] ignored
- next_op  in  2  current operator slot from the slot counter
- next_ch  in  3  current channel slot from the slot counter
- up_keyon  out  1  head entry valid / update request
- keyon_op  out  4  head operator mask
- keyon_ch  out  3  head channel code
- pending  out  clog2(depth)+1  entries queued
- full  out  1  pending==depth
- drop_err  out  1  sticky: a write was discarded because the FIFO was full

Behaviour:
- Reset: all outputs 0; FIFO pointers and count cleared; drop_err cleared. Reset takes priority over wr and pop in the same cycle.
- Channel validity:
  - num_ch=6: codes 3 and 7 are invalid.
  - num_ch=3: codes 3..7 are invalid.
  - An invalid write is silently discarded: no push, no drop_err.
- Push: on a clk edge with wr=1, valid channel and not full, store {din[7:4],din[2:0]} at the write pointer. Pointer wraps modulo depth.
- Full: wr with a valid channel while full discards the write and sets drop_err=1. drop_err is cleared only by rst.
- Outputs:
  - keyon_op/keyon_ch are driven from storage at the read pointer; there is no combinational path from wr/din.
  - up_keyon = (pending!=0).
  - A pushed entry into an empty FIFO is visible one clk after the wr edge.
- Commit/pop: on a clk edge with clk_en=1, up_keyon=1, next_ch==keyon_ch and next_op==3, the read pointer advances (wraps modulo depth).
  - The datapath captures the entry on this same edge.
  - The next entry is presented on the following cycle.
  - The same entry is never committed twice.
- Simultaneous push and pop: both performed; pending unchanged. A push into an empty FIFO cannot pop in the same cycle.
- Ordering is strict FIFO. Same-channel writes commit in write order, one per 24-slot rotation.
- Latency: a head entry commits within at most 24 clk_en pulses.
- No clk_en: entries are held indefinitely and writes are still accepted.
- State machine, derived from pending:
  - EMPTY -> ACTIVE on push.
  - ACTIVE -> EMPTY on a pop with pending==1 and no push.
  - ACTIVE -> FULL on a push reaching depth.
  - FULL -> ACTIVE on pop.
- Reset mid-operation: queued entries are lost. up_keyon=0 on the cycle after the reset edge.

Test Plan:
- Single write: reset, wr din=0xF1, clk_en continuous, counters cycling from op0/ch0 -> up_keyon=1 next clk, keyon_op=0xF, keyon_ch=1; pop at the first edge with next_ch=1, next_op=3; then up_keyon=0, pending=0.
- Burst: four consecutive writes 0x10, 0x21, 0x42, 0x84 with depth=4 -> full=1; commits occur in write order on the ch0, ch1, ch2, ch4 op3 slots; drop_err stays 0.
- Overflow and invalid: fill 4 entries, write 0xF5 -> discarded, drop_err=1, pending=4. Write 0xF3 and 0xF7 -> ignored, drop_err unchanged. With num_ch=3, write 0xF4 -> ignored.
- Simultaneous: pending=2; wr on the exact commit edge -> pending stays 2 and the new entry becomes the tail.
- Gated enable: hold clk_en=0 for 100 clks with a match present -> no pop. Raise clk_en at a matching slot -> a single pop.
- Reset mid-run: pending=3, assert rst for 1 clk together with wr -> pending=0, up_keyon=0, drop_err=0, the write is not stored.

Source files
------------

// File: rtl/jt12_kon_sched.sv
// Key-on write scheduler: queues decoded reg 0x28 writes and presents the head entry
// to the key-on datapath until its channel's operator-3 slot.
module jt12_kon_sched #(
   parameter int unsigned num_ch = 6,
   parameter int unsigned depth  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic                     wr,
   input  logic [7:0]               din,
   input  logic [1:0]               next_op,
   input  logic [2:0]               next_ch,
   output logic                     up_keyon,
   output logic [3:0]               keyon_op,
   output logic [2:0]               keyon_ch,
   output logic [$clog2(depth):0]   pending,
   output logic                     full,
   output logic                     drop_err
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

   state_e         state_q;
   logic [3:0]     mem_op_q [depth];
   logic [2:0]     mem_ch_q [depth];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PW-1:0]  cnt_q, cnt_d;
   logic           drop_q;
   logic           ch_valid, push, pop;
   logic           unused_din3;

   assign unused_din3 = din[3];

   always_comb begin
      ch_valid = 1'b0;
      if (num_ch == 3) ch_valid = din[2:0] < 3'd3;
      else             ch_valid = (din[2:0] != 3'd3) && (din[2:0] != 3'd7);
   end

   assign push = wr && ch_valid && (state_q != StFull);
   // Pop on the edge where the datapath samples the head entry
   assign pop  = clk_en && up_keyon && (next_ch == keyon_ch) && (next_op == 2'd3);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + PW'(1);
      else if (pop && !push) cnt_d = cnt_q - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         drop_q   <= 1'b0;
         for (int i = 0; i < int'(depth); i++) begin
            mem_op_q[i] <= '0;
            mem_ch_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_op_q[wr_ptr_q] <= din[7:4];
            mem_ch_q[wr_ptr_q] <= din[2:0];
            wr_ptr_q           <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (wr && ch_valid && state_q == StFull) drop_q <= 1'b1;
         cnt_q <= cnt_d;
         unique case (state_q)
            StEmpty:  if (push) state_q <= StActive;
            StActive: begin
               if (push && !pop && cnt_q == PW'(depth - 1)) state_q <= StFull;
               else if (pop && !push && cnt_q == PW'(1))    state_q <= StEmpty;
            end
            StFull:   if (pop) state_q <= StActive;
            default:  state_q <= StEmpty;
         endcase
      end
   end

   assign up_keyon = (state_q != StEmpty);
   assign full     = (state_q == StFull);
   assign pending  = cnt_q;
   assign drop_err = drop_q;
   assign keyon_op = mem_op_q[rd_ptr_q];
   assign keyon_ch = mem_ch_q[rd_ptr_q];

endmodule
